// File: rtl/cnt4_ctrl.sv
// Run controller for the 4-bit event counter: clears it, paces increment enables
// through a prescaler, and stops at a latched limit with pause/resume/abort support.
module cnt4_ctrl #(
  parameter int DIV_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic             stop,
  input  logic [DIV_W-1:0] div_val,
  input  logic [3:0]       limit,
  input  logic [3:0]       count,
  output logic             cnt_en,
  output logic             cnt_rst_n,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [DIV_W-1:0] PRE_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [DIV_W-1:0] pre_q, pre_d;
  logic [DIV_W-1:0] div_l_q, div_l_d;
  logic [3:0]       lim_l_q, lim_l_d;

  logic pre_zero;
  logic at_limit;

  assign pre_zero = (pre_q == '0);
  assign at_limit = (count == lim_l_q);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      pre_q   <= '0;
      div_l_q <= '0;
      lim_l_q <= '0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      div_l_q <= div_l_d;
      lim_l_q <= lim_l_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    div_l_d = div_l_q;
    lim_l_d = lim_l_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_IDLE == ST_IDLE ? ST_CLEAR : ST_IDLE;
      end
      ST_CLEAR: begin
        div_l_d = div_val;
        lim_l_d = limit;
        pre_d   = div_val;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        // A stop freezes the prescaler so a later resume keeps its phase.
        if (stop) begin
          state_d = ST_PAUSE;
        end else if (at_limit) begin
          state_d = ST_DONE;
        end else if (pre_zero) begin
          pre_d = div_l_q;
        end else begin
          pre_d = pre_q - PRE_ONE;
        end
      end
      ST_PAUSE: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (start) begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    cnt_en    = (state_q == ST_RUN) && pre_zero && !at_limit;
    cnt_rst_n = (state_q != ST_CLEAR);
    busy      = (state_q == ST_CLEAR) || (state_q == ST_RUN) || (state_q == ST_PAUSE);
    done      = (state_q == ST_DONE);
  end

endmodule

// File: tb/tb_cnt4_ctrl.sv
// Directed bench for cnt4_ctrl with a behavioural model of the 4-bit counter
// it drives; every expected value is a hand-computed constant.
module tb_cnt4_ctrl;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic [7:0] div_val = 8'd0;
   logic [3:0] limit = 4'd0;
   logic [3:0] count = 4'd0;
   logic       cnt_en;
   logic       cnt_rst_n;
   logic       busy;
   logic       done;

   int total = 0;
   int bad = 0;

   cnt4_ctrl #(.DIV_W(8)) dut (
      .CLK(CLK),
      .RST(RST),
      .start(start),
      .stop(stop),
      .div_val(div_val),
      .limit(limit),
      .count(count),
      .cnt_en(cnt_en),
      .cnt_rst_n(cnt_rst_n),
      .busy(busy),
      .done(done)
   );

   // Free-running 10 ns clock
   always #5 CLK = ~CLK;

   // Stand-in for the event counter: synchronous clear, increment on enable
   always @(posedge CLK) begin
      if (!cnt_rst_n) count <= 4'd0;
      else if (cnt_en) count <= count + 4'd1;
   end

   // Backstop so a wedged run still terminates
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One complete run from a start pulse; tick numbers count edges from the start edge (tick 1)
   task automatic applyStimulus(input string tag, input logic [7:0] dv, input logic [3:0] lim,
                                input int expDone, input int expEn, input int expFirst,
                                input int expGap);
      int enCnt, clrCnt, doneTick, firstEn, lastEn, gap;
      enCnt = 0; clrCnt = 0; doneTick = 0; firstEn = 0; lastEn = 0; gap = 0;
      div_val = dv;
      limit = lim;
      start = 1'b1;
      for (int i = 1; i <= 400 && doneTick == 0; i++) begin
         tick;
         start = 1'b0;
         if (cnt_en) begin
            enCnt++;
            if (firstEn == 0) firstEn = i;
            else gap = i - lastEn;
            lastEn = i;
         end
         if (!cnt_rst_n) clrCnt++;
         if (done) doneTick = i;
      end
      checkOutput({tag, "_doneTick"}, doneTick, expDone);
      checkOutput({tag, "_enables"}, enCnt, expEn);
      checkOutput({tag, "_clears"}, clrCnt, 1);
      if (expEn > 0) checkOutput({tag, "_firstEn"}, firstEn, expFirst);
      if (expEn > 1) checkOutput({tag, "_gap"}, gap, expGap);
      checkOutput({tag, "_countAtDone"}, count, lim);
      tick;
      checkOutput({tag, "_busyAfter"}, busy, 0);
      checkOutput({tag, "_doneAfter"}, done, 0);
      checkOutput({tag, "_countHeld"}, count, lim);
   endtask

   initial begin
      int enCnt, clrCnt, doneTick, busyLow, doneSeen;

      // Power-on reset values
      #3;
      checkOutput("rst_cnt_en", cnt_en, 0);
      checkOutput("rst_cnt_rst_n", cnt_rst_n, 1);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      #4 RST = 1'b1;
      tick;

      applyStimulus("basic", 8'd0, 4'd3, 6, 3, 2, 1);
      applyStimulus("prescale", 8'd4, 4'd2, 13, 2, 6, 5);

      // Pause after two increments, hold, then resume without a clear
      div_val = 8'd2;
      limit = 4'd5;
      start = 1'b1;
      enCnt = 0;
      for (int i = 1; i <= 8; i++) begin
         tick;
         start = 1'b0;
         if (cnt_en) enCnt++;
      end
      checkOutput("pause_preEnables", enCnt, 2);
      checkOutput("pause_preCount", count, 2);
      stop = 1'b1;
      tick;
      stop = 1'b0;
      checkOutput("pause_busy", busy, 1);
      enCnt = 0;
      busyLow = 0;
      for (int i = 0; i < 10; i++) begin
         tick;
         if (cnt_en) enCnt++;
         if (!busy) busyLow++;
      end
      checkOutput("pause_heldEnables", enCnt, 0);
      checkOutput("pause_heldBusyLow", busyLow, 0);
      checkOutput("pause_heldCount", count, 2);
      start = 1'b1;
      enCnt = 0; clrCnt = 0; doneTick = 0;
      for (int i = 1; i <= 50 && doneTick == 0; i++) begin
         tick;
         start = 1'b0;
         if (cnt_en) enCnt++;
         if (!cnt_rst_n) clrCnt++;
         if (done) doneTick = i;
      end
      checkOutput("resume_doneTick", doneTick, 11);
      checkOutput("resume_enables", enCnt, 3);
      checkOutput("resume_clears", clrCnt, 0);
      checkOutput("resume_count", count, 5);
      tick;

      // Abort from PAUSE with start and stop together; stop wins
      div_val = 8'd2;
      limit = 4'd5;
      start = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         tick;
         start = 1'b0;
      end
      stop = 1'b1;
      tick;
      stop = 1'b0;
      checkOutput("abort_pausedBusy", busy, 1);
      checkOutput("abort_pausedCount", count, 1);
      start = 1'b1;
      stop = 1'b1;
      tick;
      start = 1'b0;
      stop = 1'b0;
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_done", done, 0);
      checkOutput("abort_cnt_rst_n", cnt_rst_n, 1);
      doneSeen = 0;
      busyLow = 0;
      for (int i = 0; i < 3; i++) begin
         tick;
         if (done) doneSeen++;
         if (!busy) busyLow++;
      end
      checkOutput("abort_noDone", doneSeen, 0);
      checkOutput("abort_staysIdle", busyLow, 3);
      checkOutput("abort_countHeld", count, 1);

      // Stop while idle does nothing
      stop = 1'b1;
      tick;
      stop = 1'b0;
      checkOutput("idleStop_busy", busy, 0);
      checkOutput("idleStop_cnt_rst_n", cnt_rst_n, 1);
      tick;
      checkOutput("idleStop_busyLater", busy, 0);

      applyStimulus("limit0", 8'd3, 4'd0, 3, 0, 0, 0);
      applyStimulus("limit15", 8'd0, 4'd15, 18, 15, 2, 1);

      // Asynchronous reset in the middle of a run
      div_val = 8'd0;
      limit = 4'd10;
      start = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         tick;
         start = 1'b0;
      end
      checkOutput("midrst_count", count, 5);
      checkOutput("midrst_enBefore", cnt_en, 1);
      RST = 1'b0;
      #1;
      checkOutput("midrst_cnt_en", cnt_en, 0);
      checkOutput("midrst_cnt_rst_n", cnt_rst_n, 1);
      checkOutput("midrst_busy", busy, 0);
      checkOutput("midrst_done", done, 0);
      #1 RST = 1'b1;
      tick;
      tick;
      checkOutput("postrst_busy", busy, 0);
      checkOutput("postrst_cnt_en", cnt_en, 0);
      applyStimulus("restart", 8'd1, 4'd2, 7, 2, 3, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
